// File: rtl/sdram_arbiter3.sv
// sdram_arbiter3
// Three-requester arbiter/sequencer in front of a single-command SDRAM
// controller. One transaction is in flight at a time; read responses are
// routed back to the requester that owns the current transaction.
//
// Priority: video always wins. CPU and DMA alternate round-robin, but DMA
// may only take consecutive grants from a waiting CPU up to DMA_MAX_RUN.
//
// Ports
//   clk_i, rst_n_i             clock, asynchronous active-low reset
//   {vid,cpu,dma}_cmd_*        command request/accept per requester
//   {cpu,dma}_wr/wdata/wmask   write payload (video is read-only)
//   {vid,cpu,dma}_resp_*       per-requester read beat strobes
//   rdata_o                    shared read data, qualified by a resp_valid
//   sdram_*                    command/response interface to the controller
//   busy_o                     a transaction is being issued or awaited
module sdram_arbiter3 #(
  parameter int ADDR_W      = 24,
  parameter int DMA_MAX_RUN = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  // video requester (read-only)
  input  logic              vid_cmd_valid_i,
  output logic              vid_cmd_ready_o,
  input  logic [ADDR_W-1:0] vid_addr_i,
  input  logic              vid_burst_i,
  output logic              vid_resp_valid_o,
  output logic              vid_resp_last_o,
  // cpu requester
  input  logic              cpu_cmd_valid_i,
  output logic              cpu_cmd_ready_o,
  input  logic              cpu_wr_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic              cpu_burst_i,
  input  logic [15:0]       cpu_wdata_i,
  input  logic [1:0]        cpu_wmask_i,
  output logic              cpu_resp_valid_o,
  output logic              cpu_resp_last_o,
  // dma requester
  input  logic              dma_cmd_valid_i,
  output logic              dma_cmd_ready_o,
  input  logic              dma_wr_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic              dma_burst_i,
  input  logic [15:0]       dma_wdata_i,
  input  logic [1:0]        dma_wmask_i,
  output logic              dma_resp_valid_o,
  output logic              dma_resp_last_o,
  // shared read data
  output logic [15:0]       rdata_o,
  // sdram controller side
  output logic              sdram_cmd_valid_o,
  input  logic              sdram_cmd_ready_i,
  output logic              sdram_rd_o,
  output logic              sdram_wr_o,
  output logic [ADDR_W-1:0] sdram_addr_o,
  output logic [15:0]       sdram_wdata_o,
  output logic [1:0]        sdram_wmask_o,
  output logic              sdram_burst_o,
  input  logic              sdram_resp_valid_i,
  input  logic              sdram_resp_last_i,
  input  logic [15:0]       sdram_rdata_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_DMA  = 2'd3
  } owner_t;

  localparam logic [3:0] RUN_MAX = 4'(DMA_MAX_RUN);
  localparam logic [3:0] RUN_SAT = 4'd15;

  state_t              state_r, state_s;
  owner_t              owner_r, owner_s;
  logic                rr_dma_r, rr_dma_s;   // 1: last CPU/DMA grant went to DMA
  logic [3:0]          dma_run_r, dma_run_s;

  logic                gnt_vid_s, gnt_cpu_s, gnt_dma_s;
  logic                sel_valid_s, sel_wr_s, sel_burst_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [15:0]         sel_wdata_s;
  logic [1:0]          sel_wmask_s;
  logic                hs_s;

  // Arbitration decision among the current requests (used only in IDLE).
  always_comb begin
    gnt_vid_s = 1'b0;
    gnt_cpu_s = 1'b0;
    gnt_dma_s = 1'b0;
    if (vid_cmd_valid_i) begin
      gnt_vid_s = 1'b1;
    end else if (cpu_cmd_valid_i && dma_cmd_valid_i) begin
      // DMA takes its turn only if CPU had the last one and the run cap allows.
      if (!rr_dma_r && (dma_run_r < RUN_MAX)) begin
        gnt_dma_s = 1'b1;
      end else begin
        gnt_cpu_s = 1'b1;
      end
    end else if (cpu_cmd_valid_i) begin
      gnt_cpu_s = 1'b1;
    end else if (dma_cmd_valid_i) begin
      gnt_dma_s = 1'b1;
    end else begin
      gnt_vid_s = 1'b0;
    end
  end

  // Select the current owner's live request payload.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_wr_s    = 1'b0;
    sel_burst_s = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = 16'd0;
    sel_wmask_s = 2'd0;
    case (owner_r)
      OWN_VID: begin
        sel_valid_s = vid_cmd_valid_i;
        sel_burst_s = vid_burst_i;
        sel_addr_s  = vid_addr_i;
      end
      OWN_CPU: begin
        sel_valid_s = cpu_cmd_valid_i;
        sel_wr_s    = cpu_wr_i;
        sel_burst_s = cpu_burst_i;
        sel_addr_s  = cpu_addr_i;
        sel_wdata_s = cpu_wdata_i;
        sel_wmask_s = cpu_wmask_i;
      end
      OWN_DMA: begin
        sel_valid_s = dma_cmd_valid_i;
        sel_wr_s    = dma_wr_i;
        sel_burst_s = dma_burst_i;
        sel_addr_s  = dma_addr_i;
        sel_wdata_s = dma_wdata_i;
        sel_wmask_s = dma_wmask_i;
      end
      default: begin
        sel_valid_s = 1'b0;
      end
    endcase
  end

  // FSM next state, bookkeeping updates, command drive and response routing.
  always_comb begin
    state_s           = state_r;
    owner_s           = owner_r;
    rr_dma_s          = rr_dma_r;
    dma_run_s         = dma_run_r;
    hs_s              = 1'b0;
    vid_cmd_ready_o   = 1'b0;
    cpu_cmd_ready_o   = 1'b0;
    dma_cmd_ready_o   = 1'b0;
    vid_resp_valid_o  = 1'b0;
    vid_resp_last_o   = 1'b0;
    cpu_resp_valid_o  = 1'b0;
    cpu_resp_last_o   = 1'b0;
    dma_resp_valid_o  = 1'b0;
    dma_resp_last_o   = 1'b0;
    rdata_o           = 16'd0;
    sdram_cmd_valid_o = 1'b0;
    sdram_rd_o        = 1'b0;
    sdram_wr_o        = 1'b0;
    sdram_addr_o      = '0;
    sdram_wdata_o     = 16'd0;
    sdram_wmask_o     = 2'd0;
    sdram_burst_o     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (gnt_vid_s) begin
          owner_s = OWN_VID;
          state_s = ST_ISSUE;
        end else if (gnt_cpu_s) begin
          owner_s   = OWN_CPU;
          state_s   = ST_ISSUE;
          rr_dma_s  = 1'b0;
          dma_run_s = 4'd0;
        end else if (gnt_dma_s) begin
          owner_s  = OWN_DMA;
          state_s  = ST_ISSUE;
          rr_dma_s = 1'b1;
          // The run only counts grants taken while the CPU is waiting.
          if (cpu_cmd_valid_i) begin
            dma_run_s = (dma_run_r == RUN_SAT) ? RUN_SAT : dma_run_r + 4'd1;
          end else begin
            dma_run_s = 4'd0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // Payload follows the owner's inputs directly; a dropped valid simply
        // parks the command until the requester re-asserts it.
        sdram_cmd_valid_o = sel_valid_s;
        sdram_rd_o        = ~sel_wr_s;
        sdram_wr_o        = sel_wr_s;
        sdram_addr_o      = sel_addr_s;
        sdram_wdata_o     = sel_wdata_s;
        sdram_wmask_o     = sel_wmask_s;
        sdram_burst_o     = sel_burst_s & ~sel_wr_s;
        hs_s              = sel_valid_s & sdram_cmd_ready_i;
        case (owner_r)
          OWN_VID: vid_cmd_ready_o = hs_s;
          OWN_CPU: cpu_cmd_ready_o = hs_s;
          OWN_DMA: dma_cmd_ready_o = hs_s;
          default: hs_s = 1'b0;
        endcase
        if (hs_s) begin
          if (sel_wr_s) begin
            state_s = ST_IDLE;
            owner_s = OWN_NONE;
          end else begin
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (sdram_resp_valid_i) begin
          rdata_o = sdram_rdata_i;
        end else begin
          rdata_o = 16'd0;
        end
        case (owner_r)
          OWN_VID: begin
            vid_resp_valid_o = sdram_resp_valid_i;
            vid_resp_last_o  = sdram_resp_valid_i & sdram_resp_last_i;
          end
          OWN_CPU: begin
            cpu_resp_valid_o = sdram_resp_valid_i;
            cpu_resp_last_o  = sdram_resp_valid_i & sdram_resp_last_i;
          end
          OWN_DMA: begin
            dma_resp_valid_o = sdram_resp_valid_i;
            dma_resp_last_o  = sdram_resp_valid_i & sdram_resp_last_i;
          end
          default: rdata_o = 16'd0;
        endcase
        if (sdram_resp_valid_i && sdram_resp_last_i) begin
          state_s = ST_IDLE;
          owner_s = OWN_NONE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        owner_s = OWN_NONE;
      end
    endcase
  end

  // State, owner and fairness registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r   <= ST_IDLE;
      owner_r   <= OWN_NONE;
      rr_dma_r  <= 1'b1;
      dma_run_r <= 4'd0;
    end else begin
      state_r   <= state_s;
      owner_r   <= owner_s;
      rr_dma_r  <= rr_dma_s;
      dma_run_r <= dma_run_s;
    end
  end

  assign busy_o = (state_r != ST_IDLE);

endmodule

// File: tb/tb_sdram_arbiter3.sv
// Randomized bench for sdram_arbiter3: random requesters and a random SDRAM
// responder, checked every cycle against a transaction-level reference of the
// arbitration and routing rules. Index 0=vid, 1=cpu, 2=dma.
module tb_sdram_arbiter3;
  localparam int AW = 24;
  localparam int MAXRUN = 4;
  localparam int NCYC = 4000;

  logic clk = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid [3];
  logic          wd        [3];
  logic          dv        [3];
  logic          req_wr    [3];
  logic [AW-1:0] req_addr  [3];
  logic          req_burst [3];
  logic [15:0]   req_wdata [3];
  logic [1:0]    req_wmask [3];
  logic          rdy [3];
  logic          rv  [3];
  logic          rl  [3];

  logic          s_ready, s_rv, s_rl;
  logic [15:0]   s_rdata;
  logic          cmd_v, s_rd, s_wr, s_burst, busy;
  logic [AW-1:0] s_addr;
  logic [15:0]   s_wdata, rdata;
  logic [1:0]    s_wmask;

  assign dv[0] = req_valid[0] & ~wd[0];
  assign dv[1] = req_valid[1] & ~wd[1];
  assign dv[2] = req_valid[2] & ~wd[2];

  sdram_arbiter3 #(.ADDR_W(AW), .DMA_MAX_RUN(MAXRUN)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .vid_cmd_valid_i(dv[0]), .vid_cmd_ready_o(rdy[0]), .vid_addr_i(req_addr[0]),
    .vid_burst_i(req_burst[0]), .vid_resp_valid_o(rv[0]), .vid_resp_last_o(rl[0]),
    .cpu_cmd_valid_i(dv[1]), .cpu_cmd_ready_o(rdy[1]), .cpu_wr_i(req_wr[1]),
    .cpu_addr_i(req_addr[1]), .cpu_burst_i(req_burst[1]), .cpu_wdata_i(req_wdata[1]),
    .cpu_wmask_i(req_wmask[1]), .cpu_resp_valid_o(rv[1]), .cpu_resp_last_o(rl[1]),
    .dma_cmd_valid_i(dv[2]), .dma_cmd_ready_o(rdy[2]), .dma_wr_i(req_wr[2]),
    .dma_addr_i(req_addr[2]), .dma_burst_i(req_burst[2]), .dma_wdata_i(req_wdata[2]),
    .dma_wmask_i(req_wmask[2]), .dma_resp_valid_o(rv[2]), .dma_resp_last_o(rl[2]),
    .rdata_o(rdata),
    .sdram_cmd_valid_o(cmd_v), .sdram_cmd_ready_i(s_ready), .sdram_rd_o(s_rd),
    .sdram_wr_o(s_wr), .sdram_addr_o(s_addr), .sdram_wdata_o(s_wdata),
    .sdram_wmask_o(s_wmask), .sdram_burst_o(s_burst),
    .sdram_resp_valid_i(s_rv), .sdram_resp_last_i(s_rl), .sdram_rdata_i(s_rdata),
    .busy_o(busy)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a transaction is either absent, waiting for its command
  // to be accepted, or waiting for its read data.
  typedef enum {M_FREE, M_CMD, M_DATA} mphase_t;
  mphase_t mph = M_FREE;
  int  own = 0;
  bit  last_dma = 1'b1;
  int  run = 0;
  int  beats_left = 0, beat_delay = 0, beats_done = 0;
  bit  beat_q = 1'b0;
  bit  accepted [3];
  int  wait_cnt [3];
  int  max_wait = 0;
  int  hs_model [3];
  int  hs_seen [3];
  int  rst_cnt = 3;
  bit  rst_done = 1'b0;
  int  rate [3];

  function automatic int pick(input bit v0, input bit v1, input bit v2);
    if (v0) return 0;
    if (v1 && v2) return (!last_dma && run < MAXRUN) ? 2 : 1;
    if (v1) return 1;
    return 2;
  endfunction

  initial begin
    bit exp_cmdv, gen, hs;
    bit erdy [3];
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0; wd[i] = 1'b0; req_wr[i] = 1'b0; req_addr[i] = '0;
      req_burst[i] = 1'b0; req_wdata[i] = 16'd0; req_wmask[i] = 2'd0;
      accepted[i] = 1'b0; wait_cnt[i] = 0; hs_model[i] = 0; hs_seen[i] = 0;
    end
    s_ready = 1'b0; s_rv = 1'b0; s_rl = 1'b0; s_rdata = 16'd0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      // reset sequencing
      if (!rst_n_i) begin
        if (rst_cnt == 0) rst_n_i = 1'b1;
        else rst_cnt--;
      end else if (!rst_done && cyc >= 2600 && mph == M_DATA &&
                   (beats_done >= 3 || cyc >= 2800)) begin
        rst_n_i = 1'b0; rst_cnt = 3; rst_done = 1'b1;
        mph = M_FREE; last_dma = 1'b1; run = 0;
      end
      // traffic profile
      if (cyc < 1500) begin rate[0] = 10; rate[1] = 40; rate[2] = 40; end
      else if (cyc < 2500) begin rate[0] = 5; rate[1] = 5; rate[2] = 100; end
      else begin rate[0] = 30; rate[1] = 40; rate[2] = 60; end
      // requesters
      for (int i = 0; i < 3; i++) begin
        if (accepted[i]) begin
          req_valid[i] = 1'b0; accepted[i] = 1'b0; wait_cnt[i] = 0;
        end
        wd[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 99) < rate[i]) begin
          req_valid[i] = 1'b1;
          req_wr[i]    = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
          req_addr[i]  = AW'($urandom);
          req_burst[i] = 1'($urandom_range(0, 1));
          req_wdata[i] = 16'($urandom);
          req_wmask[i] = 2'($urandom);
        end
      end
      // illegal withdrawal of the pending command for one cycle
      if (rst_n_i && mph == M_CMD && $urandom_range(0, 19) == 0) wd[own] = 1'b1;
      // sdram responder
      s_ready = (beats_left == 0) &&
                ($urandom_range(0, 99) < ((cyc >= 1000 && cyc < 1300) ? 20 : 70));
      s_rv = 1'b0; s_rl = 1'b0; s_rdata = 16'($urandom); beat_q = 1'b0;
      if (beats_left > 0) begin
        if (beat_delay > 0) beat_delay--;
        else if ($urandom_range(0, 3) != 0) begin
          s_rv = 1'b1; s_rl = (beats_left == 1); beat_q = 1'b1;
        end
      end else if (mph != M_DATA && $urandom_range(0, 29) == 0) begin
        s_rv = 1'b1; s_rl = 1'($urandom_range(0, 1));
      end

      @(negedge clk);
      // expectations for this cycle
      exp_cmdv = rst_n_i && mph == M_CMD && dv[own];
      hs = exp_cmdv && s_ready;
      gen = rst_n_i && mph == M_DATA && s_rv;
      for (int i = 0; i < 3; i++) begin
        erdy[i] = hs && own == i;
        chk($sformatf("ready%0d", i), rdy[i], erdy[i]);
        chk($sformatf("resp_valid%0d", i), rv[i], gen && own == i);
        chk($sformatf("resp_last%0d", i), rl[i], gen && own == i && s_rl);
        if (rdy[i]) hs_seen[i]++;
      end
      chk("cmd_valid", cmd_v, exp_cmdv);
      chk("busy", busy, rst_n_i && mph != M_FREE);
      if (exp_cmdv) begin
        chk("addr", s_addr, req_addr[own]);
        chk("rd", s_rd, !req_wr[own]);
        chk("wr", s_wr, req_wr[own]);
        chk("burst", s_burst, req_burst[own] && !req_wr[own]);
        if (req_wr[own]) begin
          chk("wdata", s_wdata, req_wdata[own]);
          chk("wmask", s_wmask, req_wmask[own]);
        end
      end
      if (gen) chk("rdata", rdata, s_rdata);
      if (!rst_n_i) begin
        chk("rst_rd", s_rd, 1'b0);
        chk("rst_wr", s_wr, 1'b0);
        chk("rst_addr", s_addr, '0);
        chk("rst_wdata", s_wdata, 16'd0);
        chk("rst_wmask", s_wmask, 2'd0);
        chk("rst_burst", s_burst, 1'b0);
        chk("rst_rdata", rdata, 16'd0);
      end

      // advance the reference
      if (beat_q) beats_left--;
      for (int i = 0; i < 3; i++) begin
        if (req_valid[i]) wait_cnt[i]++;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
      if (rst_n_i) begin
        case (mph)
          M_FREE: begin
            if (dv[0] || dv[1] || dv[2]) begin
              own = pick(dv[0], dv[1], dv[2]);
              if (own == 1) begin last_dma = 1'b0; run = 0; end
              else if (own == 2) begin
                last_dma = 1'b1;
                run = dv[1] ? ((run < 15) ? run + 1 : 15) : 0;
              end
              mph = M_CMD;
            end
          end
          M_CMD: begin
            if (hs) begin
              accepted[own] = 1'b1;
              hs_model[own]++;
              if (req_wr[own]) mph = M_FREE;
              else begin
                mph = M_DATA;
                beats_left = req_burst[own] ? 8 : 1;
                beat_delay = $urandom_range(0, 2);
                beats_done = 0;
              end
            end
          end
          M_DATA: begin
            if (gen) beats_done++;
            if (gen && s_rl) mph = M_FREE;
          end
          default: mph = M_FREE;
        endcase
      end
    end

    chk("reset_mid_resp", 32'(rst_done), 32'd1);
    chk("max_wait_ok", 32'(max_wait <= 400), 32'd1);
    chk("hs_count_vid", hs_seen[0], hs_model[0]);
    chk("hs_count_cpu", hs_seen[1], hs_model[1]);
    chk("hs_count_dma", hs_seen[2], hs_model[2]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
